cache_ctrl_fsm: RTL
===================

// Module: cache_ctrl_fsm
// PURPOSE
//  Control FSM for the 2-way set-associative, write-back, write-allocate L1 cache.
//  Sequences the two per-way tag comparators (valid && tag match) and the tag/valid/dirty/data/LRU arrays.
//  Runs physical-memory writeback and fill on a miss.
//  Sits between the CPU-side request port and the line-wide pmem port.
//  Also keeps saturating hit and miss counters.
// PARAMETERS
//  s_offset  5   line offset bits (32-byte line)
//  s_index   3   set index bits (8 sets)
//  s_cnt     16  width of hit/miss counters
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  mem_read   in   1      CPU read request; held until mem_resp
//  mem_write  in   1      CPU write request; held until mem_resp
//  hit0       in   1      way0 comparator result
//  hit1       in   1      way1 comparator result
//  dirty0     in   1      way0 dirty bit, indexed set
//  dirty1     in   1      way1 dirty bit, indexed set
//  lru        in   1      LRU bit of indexed set (0 = way0 is victim)
//  pmem_resp  in   1      pmem transfer complete, 1-cycle pulse
//  mem_resp   out  1      CPU request done, 1-cycle pulse
//  pmem_read  out  1      line fill request
//  pmem_write out  1      line writeback request
//  pmem_addr_sel out 1    0 = {cpu tag,index}, 1 = {victim tag,index}
//  way_sel    out  1      way addressed by array loads / writeback data mux
//  load_tag   out  1      write tag array[way_sel]
//  load_valid out  1      set valid[way_sel]
//  load_data  out  1      write data array[way_sel]
//  data_src   out  1      0 = CPU write data w/ byte mask, 1 = pmem line
//  load_dirty out  1      write dirty[way_sel] <= dirty_in
//  dirty_in   out  1      dirty value to write
//  load_lru   out  1      write LRU bit <= lru_in
//  lru_in     out  1      new LRU value (= ~accessed way)
//  hit_cnt    out  s_cnt  hits since reset, saturating
//  miss_cnt   out  s_cnt  misses since reset, saturating
// BEHAVIOUR
//  States: IDLE, CHECK, WB, FILL.
//  Reset: state <= IDLE; hit_cnt = miss_cnt = 0.
//   All outputs are combinational from state+inputs and are forced 0 while rst=1.
//   Reset mid-WB/FILL abandons the transfer; pmem_read/pmem_write drop in the rst cycle.
//  IDLE:
//   req = mem_read|mem_write; if req -> CHECK next cycle (tag arrays are sync-read). Outputs 0.
//  CHECK, hit = hit0|hit1; hit way = hit0 ? 0 : 1 (both set is illegal; way0 wins):
//   - mem_resp=1; load_lru=1; lru_in = ~way; hit_cnt++ (unless wrapped back from FILL).
//   - If mem_write: also load_data=1, data_src=0, load_dirty=1, dirty_in=1, way_sel=way.
//   - Next state IDLE.
//  CHECK, miss: victim v = lru; way_sel = v; miss_cnt++.
//   - Next state WB if dirty[v], else FILL.
//  WB: pmem_write=1, pmem_addr_sel=1, way_sel=v; hold until pmem_resp, then -> FILL.
//  FILL: pmem_read=1, pmem_addr_sel=0, way_sel=v; hold until pmem_resp.
//   - On pmem_resp: load_tag, load_valid, load_data (data_src=1), load_dirty with dirty_in=0.
//   - Next state CHECK; the retried CHECK hits and services the request.
//   - Hit in retry CHECK is not counted; a flag set in FILL and cleared in CHECK tracks this.
//  Victim: v is latched on leaving CHECK-miss and stays stable through WB/FILL.
//  Both mem_read and mem_write high: treated as a write.
//  Request dropped while not in CHECK: FSM finishes WB/FILL, then returns to IDLE, no mem_resp.
//  Counters: s_cnt-bit, saturate at all-ones, never wrap.
//  Latency: hit = 2 cycles (req seen in IDLE, mem_resp in CHECK).
//   Clean miss = 3 + fill cycles; dirty miss adds WB cycles.
//  pmem_read and pmem_write are never high together.
// TESTING
//  1. Read, hit0=1 in CHECK.
//     -> mem_resp at cycle 2; load_lru=1, lru_in=1; hit_cnt=1; back to IDLE.
//  2. Write, hit1=1.
//     -> mem_resp + load_data + load_dirty (dirty_in=1) + way_sel=1 in the same cycle; lru_in=0.
//  3. Read miss, lru=0, dirty0=0, pmem_resp after 4 cycles.
//     -> FILL with pmem_read=1 for 4 cycles; array loads on resp.
//     -> CHECK hits; mem_resp; miss_cnt=1, hit_cnt=0.
//  4. Write miss, lru=1, dirty1=1.
//     -> WB (pmem_write, pmem_addr_sel=1, way_sel=1), then FILL, then CHECK write-hit.
//     -> pmem_read/pmem_write never overlap.
//  5. rst asserted during FILL.
//     -> pmem_read=0 that cycle; state IDLE; counters 0; no mem_resp.
//  6. Force hit_cnt to all-ones; issue another hit.
//     -> hit_cnt stays 0xFFFF.

Source files
------------

// File: rtl/cache_ctrl_fsm.sv
// Control FSM for a 2-way set-associative, write-back, write-allocate L1 cache.
// Sequences tag check, victim writeback and line fill, and keeps saturating hit/miss counters.
module cache_ctrl_fsm #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int s_cnt    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             hit0,
  input  logic             hit1,
  input  logic             dirty0,
  input  logic             dirty1,
  input  logic             lru,
  input  logic             pmem_resp,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic             pmem_addr_sel,
  output logic             way_sel,
  output logic             load_tag,
  output logic             load_valid,
  output logic             load_data,
  output logic             data_src,
  output logic             load_dirty,
  output logic             dirty_in,
  output logic             load_lru,
  output logic             lru_in,
  output logic [s_cnt-1:0] hit_cnt,
  output logic [s_cnt-1:0] miss_cnt
);

  if (s_cnt < 1 || s_offset < 0 || s_index < 0) begin : g_cfg_err
    $error("cache_ctrl_fsm: illegal geometry parameters");
  end

  typedef enum logic [1:0] {IDLE, CHECK, WB, FILL} state_e;

  state_e           state_q, state_d;
  logic             victim_q, victim_d;
  logic             retry_q, retry_d;
  logic [s_cnt-1:0] hit_cnt_q, hit_cnt_d;
  logic [s_cnt-1:0] miss_cnt_q, miss_cnt_d;

  logic req;
  logic hit;
  logic hit_way;
  logic victim_dirty;

  assign req          = mem_read | mem_write;
  assign hit          = hit0 | hit1;
  assign hit_way      = hit0 ? 1'b0 : 1'b1;
  assign victim_dirty = lru ? dirty1 : dirty0;

  function automatic logic [s_cnt-1:0] sat_inc(input logic [s_cnt-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    retry_d       = retry_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    way_sel       = 1'b0;
    load_tag      = 1'b0;
    load_valid    = 1'b0;
    load_data     = 1'b0;
    data_src      = 1'b0;
    load_dirty    = 1'b0;
    dirty_in      = 1'b0;
    load_lru      = 1'b0;
    lru_in        = 1'b0;
    hit_cnt       = hit_cnt_q;
    miss_cnt      = miss_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req) state_d = CHECK;
      end
      CHECK: begin
        retry_d = 1'b0;
        state_d = IDLE;
        if (req && hit) begin
          mem_resp = 1'b1;
          load_lru = 1'b1;
          lru_in   = ~hit_way;
          // The hit that completes a fill was already counted as a miss.
          if (!retry_q) hit_cnt_d = sat_inc(hit_cnt_q);
          if (mem_write) begin
            way_sel    = hit_way;
            load_data  = 1'b1;
            load_dirty = 1'b1;
            dirty_in   = 1'b1;
          end
        end else if (req) begin
          way_sel    = lru;
          victim_d   = lru;
          miss_cnt_d = sat_inc(miss_cnt_q);
          state_d    = victim_dirty ? WB : FILL;
        end
      end
      WB: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim_q;
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        pmem_read = 1'b1;
        way_sel   = victim_q;
        if (pmem_resp) begin
          load_tag   = 1'b1;
          load_valid = 1'b1;
          load_data  = 1'b1;
          data_src   = 1'b1;
          load_dirty = 1'b1;
          // Abandoned requests skip the retry so the flag cannot leak into the next one.
          retry_d    = req;
          state_d    = req ? CHECK : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr_sel = 1'b0;
      way_sel       = 1'b0;
      load_tag      = 1'b0;
      load_valid    = 1'b0;
      load_data     = 1'b0;
      data_src      = 1'b0;
      load_dirty    = 1'b0;
      dirty_in      = 1'b0;
      load_lru      = 1'b0;
      lru_in        = 1'b0;
      hit_cnt       = '0;
      miss_cnt      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      victim_q   <= 1'b0;
      retry_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      victim_q   <= victim_d;
      retry_q    <= retry_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule
